// File: rtl/i_cache_pkg.sv
// Shared types and configuration checks for the set-associative I-cache.
// Optional feature macro used by the top: I_CACHE_PERF_EN (hit/miss counters).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

// Elaboration-time guard against unsupported geometry; expands to a generate block.
`define I_CACHE_PARAM_CHECK(WAYS_P, IDX_P, OFF_P) \
  if (!i_cache_pkg::params_ok(WAYS_P, IDX_P, OFF_P)) begin : g_bad_params \
    $error("i_cache_assoc: unsupported WAYS/INDEX_WIDTH/BLOCK_OFFSET_WIDTH"); \
  end

package i_cache_pkg;
  localparam int ADDR_W = `ADDR_WIDTH;
  localparam int DATA_W = `DATA_WIDTH;

  typedef enum logic [1:0] {READY, REFILL_REQUEST, REFILL_DATA, REREAD} state_e;

  // Wide enough for the largest supported way count (8).
  typedef logic [2:0] way_t;

  function automatic bit params_ok(input int ways, input int idx_w, input int off_w);
    return (ways == 1 || ways == 2 || ways == 4 || ways == 8) &&
           (idx_w > 0) && (off_w >= 1) && (off_w <= 4) &&
           ((ADDR_W - idx_w - off_w - 2) > 0);
  endfunction
endpackage

// File: rtl/i_cache_victim_sel.sv
// Replacement choice: lowest-numbered invalid way, otherwise the set's round-robin pointer.
module i_cache_victim_sel
  import i_cache_pkg::*;
#(
  parameter int WAYS        = 2,
  parameter int INDEX_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_WIDTH-1:0] sel_index_i,
  input  logic [WAYS-1:0]        valid_i,
  input  logic                   upd_en_i,
  input  logic [INDEX_WIDTH-1:0] upd_index_i,
  output way_t                   victim_o,
  output logic                   by_rr_o
);
  localparam int SETS = 1 << INDEX_WIDTH;

  way_t rr_q [SETS];

  // Invalid-first search; the descending loop leaves the lowest invalid way selected.
  always_comb begin
    victim_o = rr_q[sel_index_i];
    by_rr_o  = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) begin
        victim_o = way_t'(w);
        by_rr_o  = 1'b0;
      end
    end
  end

  // Per-set round-robin pointer, advanced modulo WAYS when an RR-chosen line completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (upd_en_i) begin
      rr_q[upd_index_i] <= (rr_q[upd_index_i] == way_t'(WAYS - 1)) ? '0
                           : rr_q[upd_index_i] + way_t'(1);
    end
  end
endmodule

// File: rtl/i_cache_assoc.sv
// N-way set-associative instruction cache with 1-cycle hit latency.
// Banks are read synchronously with i_pc_next's index so data lines up with i_pc_current.
// Optional: define I_CACHE_PERF_EN to add saturating hit_count / miss_count ports.
// Handshakes: an AR transfer happens on a cycle with ARVALID && ARREADY; ARVALID and ARADDR
// stay stable until then. RREADY is always 1; a beat counts only when RVALID is high in
// REFILL_DATA, beats in any other state are discarded.
module i_cache_assoc
  import i_cache_pkg::*;
#(
  parameter int WAYS               = 2,
  parameter int INDEX_WIDTH        = 5,
  parameter int BLOCK_OFFSET_WIDTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_pc_current,
  input  logic [ADDR_W-1:0] i_pc_next,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [ADDR_W-1:0] mem_araddr_o,
  output logic [7:0]        mem_arlen_o,
  output logic              mem_arvalid_o,
  output logic [3:0]        mem_arid_o,
  input  logic              mem_arready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_rvalid_i,
  input  logic [3:0]        mem_rid_i,
  output logic              mem_rready_o,
  output state_e            state_o
`ifdef I_CACHE_PERF_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);
  localparam int LINE_SIZE = 1 << BLOCK_OFFSET_WIDTH;
  localparam int SETS      = 1 << INDEX_WIDTH;
  localparam int LOW_W     = BLOCK_OFFSET_WIDTH + 2;
  localparam int TAG_W     = ADDR_W - INDEX_WIDTH - LOW_W;
  localparam logic [BLOCK_OFFSET_WIDTH-1:0] BEAT_ONE = 1;

  `I_CACHE_PARAM_CHECK(WAYS, INDEX_WIDTH, BLOCK_OFFSET_WIDTH)

  // Address fields
  logic [BLOCK_OFFSET_WIDTH-1:0] cur_off;
  logic [INDEX_WIDTH-1:0]        cur_idx, nxt_idx;
  logic [TAG_W-1:0]              cur_tag;
  logic                          unused_bits;
  assign cur_off = i_pc_current[LOW_W-1:2];
  assign cur_idx = i_pc_current[LOW_W +: INDEX_WIDTH];
  assign cur_tag = i_pc_current[ADDR_W-1 -: TAG_W];
  assign nxt_idx = i_pc_next[LOW_W +: INDEX_WIDTH];
  assign unused_bits = ^{i_pc_current[1:0], i_pc_next[LOW_W-1:0],
                         i_pc_next[ADDR_W-1 -: TAG_W], mem_rid_i};

  // Storage: data/tag banks (synchronous read) and valid bits in flops
  logic [DATA_W-1:0] data_mem  [WAYS][LINE_SIZE][SETS];
  logic [TAG_W-1:0]  tag_mem   [WAYS][SETS];
  logic [DATA_W-1:0] data_rd_q [WAYS][LINE_SIZE];
  logic [TAG_W-1:0]  tag_rd_q  [WAYS];
  logic [WAYS-1:0]   valid_q   [SETS];

  state_e                        state_q, state_d;
  logic [BLOCK_OFFSET_WIDTH-1:0] beat_q, beat_d;
  logic [TAG_W-1:0]              r_tag_q;
  logic [INDEX_WIDTH-1:0]        r_index_q;
  way_t                          victim_q, sel_victim;
  logic                          by_rr_q, sel_by_rr;
  logic [WAYS-1:0]               match;
  logic                          miss_go, ar_done, beat_we, line_done;

  i_cache_victim_sel #(.WAYS(WAYS), .INDEX_WIDTH(INDEX_WIDTH)) u_victim_sel (
    .clk         (clk),
    .rst         (rst),
    .sel_index_i (cur_idx),
    .valid_i     (valid_q[cur_idx]),
    .upd_en_i    (line_done && by_rr_q),
    .upd_index_i (r_index_q),
    .victim_o    (sel_victim),
    .by_rr_o     (sel_by_rr)
  );

  // Tag compare and hit-way data select (at most one way may match)
  always_comb begin
    match      = '0;
    out_data_o = '0;
    for (int w = 0; w < WAYS; w++) begin
      match[w] = valid_q[cur_idx][w] && (tag_rd_q[w] == cur_tag);
      if (match[w]) out_data_o = out_data_o | data_rd_q[w][cur_off];
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    out_valid_o   = 1'b0;
    mem_arvalid_o = 1'b0;
    miss_go       = 1'b0;
    ar_done       = 1'b0;
    beat_we       = 1'b0;
    line_done     = 1'b0;
    case (state_q)
      READY: begin
        if (|match) begin
          out_valid_o = 1'b1;
        end else begin
          miss_go = 1'b1;
          state_d = REFILL_REQUEST;
        end
      end
      REFILL_REQUEST: begin
        mem_arvalid_o = 1'b1;
        if (mem_arready_i) begin
          ar_done = 1'b1;
          state_d = REFILL_DATA;
        end
      end
      REFILL_DATA: begin
        if (mem_rvalid_i) begin
          beat_we = 1'b1;
          beat_d  = beat_q + BEAT_ONE;
          if (beat_q == '1) begin
            line_done = 1'b1;
            state_d   = REREAD;
          end
        end
      end
      REREAD:  state_d = READY;
      default: state_d = READY;
    endcase
  end

  assign mem_araddr_o = {r_tag_q, r_index_q, {LOW_W{1'b0}}};
  assign mem_arlen_o  = 8'(LINE_SIZE);
  assign mem_arid_o   = '0;
  assign mem_rready_o = 1'b1;
  assign state_o      = state_q;

  // FSM, miss context and valid bits; victim is invalidated at the AR handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= READY;
      beat_q    <= '0;
      r_tag_q   <= '0;
      r_index_q <= '0;
      victim_q  <= '0;
      by_rr_q   <= 1'b0;
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (miss_go) begin
        r_tag_q   <= cur_tag;
        r_index_q <= cur_idx;
        victim_q  <= sel_victim;
        by_rr_q   <= sel_by_rr;
      end
      for (int w = 0; w < WAYS; w++) begin
        if (victim_q == way_t'(w)) begin
          if (ar_done)   valid_q[r_index_q][w] <= 1'b0;
          if (line_done) valid_q[r_index_q][w] <= 1'b1;
        end
      end
    end
  end

  // Bank read with next index; refill writes land on the same edge (REREAD picks them up)
  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      tag_rd_q[w] <= tag_mem[w][nxt_idx];
      for (int o = 0; o < LINE_SIZE; o++) data_rd_q[w][o] <= data_mem[w][o][nxt_idx];
      if (victim_q == way_t'(w)) begin
        if (beat_we)   data_mem[w][beat_q][r_index_q] <= mem_rdata_i;
        if (line_done) tag_mem[w][r_index_q]          <= r_tag_q;
      end
    end
  end

  a_single_hit: assert property (@(posedge clk) disable iff (rst)
    (state_q == READY) |-> $onehot0(match));

`ifdef I_CACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  // Saturating event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (out_valid_o && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_go && miss_cnt_q != 32'hFFFF_FFFF)    miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif
endmodule

// File: tb/tb_i_cache_assoc.sv
// Directed bench for i_cache_assoc (default geometry: 2 ways, 32 sets, 4-word lines).
// Models the fetch unit: i_pc_next = out_valid ? following address : i_pc_current.
module tb_i_cache_assoc;
  import i_cache_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] i_pc_current, i_pc_next;
  logic              out_valid_o;
  logic [DATA_W-1:0] out_data_o;
  logic [ADDR_W-1:0] mem_araddr_o;
  logic [7:0]        mem_arlen_o;
  logic              mem_arvalid_o;
  logic [3:0]        mem_arid_o;
  logic              mem_arready_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_rvalid_i;
  logic [3:0]        mem_rid_i;
  logic              mem_rready_o;
  state_e            state_o;
`ifdef I_CACHE_PERF_EN
  logic [31:0]       hit_count, miss_count;
`endif

  int n_checks  = 0;
  int n_errors  = 0;
  int hits_seen = 0;

  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  i_cache_assoc dut (
    .clk           (clk),
    .rst           (rst),
    .i_pc_current  (i_pc_current),
    .i_pc_next     (i_pc_next),
    .out_valid_o   (out_valid_o),
    .out_data_o    (out_data_o),
    .mem_araddr_o  (mem_araddr_o),
    .mem_arlen_o   (mem_arlen_o),
    .mem_arvalid_o (mem_arvalid_o),
    .mem_arid_o    (mem_arid_o),
    .mem_arready_i (mem_arready_i),
    .mem_rdata_i   (mem_rdata_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rid_i     (mem_rid_i),
    .mem_rready_o  (mem_rready_o),
    .state_o       (state_o)
`ifdef I_CACHE_PERF_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  // Memory contents returned by the bench's AXI responder
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; new current PC applied at the falling edge, outputs sampled 1ns later
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    i_pc_current = i_pc_next;
    #1;
  endtask

  task automatic expect_hit(input string tag, input logic [31:0] exp);
    check({tag, "_valid"}, 32'(out_valid_o), 32'd1);
    check({tag, "_data"}, out_data_o, exp);
    check({tag, "_no_ar"}, 32'(mem_arvalid_o), 32'd0);
    hits_seen++;
  endtask

  // Starts in a READY cycle where i_pc_current == addr misses; ends in the hit cycle
  task automatic refill(input string tag, input logic [31:0] addr, input int ar_wait,
                        input logic [31:0] exp_hit);
    logic [31:0] line;
    line = addr & 32'hFFFF_FFF0;
    check({tag, "_miss_state"}, 32'(state_o), 32'(READY));
    check({tag, "_miss_valid"}, 32'(out_valid_o), 32'd0);
    i_pc_next = addr;
    tick();
    for (int i = 0; i < ar_wait; i++) begin
      check({tag, "_wait_state"}, 32'(state_o), 32'(REFILL_REQUEST));
      check({tag, "_wait_arvalid"}, 32'(mem_arvalid_o), 32'd1);
      check({tag, "_wait_araddr"}, mem_araddr_o, line);
      check({tag, "_wait_valid"}, 32'(out_valid_o), 32'd0);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = JUNK;
      tick();
      mem_rvalid_i = 1'b0;
    end
    check({tag, "_req_state"}, 32'(state_o), 32'(REFILL_REQUEST));
    check({tag, "_arvalid"}, 32'(mem_arvalid_o), 32'd1);
    check({tag, "_araddr"}, mem_araddr_o, line);
    check({tag, "_arlen"}, 32'(mem_arlen_o), 32'd4);
    check({tag, "_arid"}, 32'(mem_arid_o), 32'd0);
    mem_arready_i = 1'b1;
    tick();
    mem_arready_i = 1'b0;
    check({tag, "_data_state"}, 32'(state_o), 32'(REFILL_DATA));
    check({tag, "_ar_dropped"}, 32'(mem_arvalid_o), 32'd0);
    for (int b = 0; b < 4; b++) begin
      check({tag, "_beat_valid"}, 32'(out_valid_o), 32'd0);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = word_at(line + 32'(4 * b));
      tick();
    end
    mem_rvalid_i = 1'b0;
    check({tag, "_reread_state"}, 32'(state_o), 32'(REREAD));
    check({tag, "_reread_valid"}, 32'(out_valid_o), 32'd0);
    tick();
    check({tag, "_ready_state"}, 32'(state_o), 32'(READY));
    expect_hit({tag, "_hit"}, exp_hit);
  endtask

  // Directed sequence
  initial begin
    rst           = 1'b0;
    i_pc_current  = 32'h040;
    i_pc_next     = 32'h040;
    mem_arready_i = 1'b0;
    mem_rvalid_i  = 1'b0;
    mem_rdata_i   = '0;
    mem_rid_i     = '0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_arvalid", 32'(mem_arvalid_o), 32'd0);
    check("rst_rready", 32'(mem_rready_o), 32'd1);
    check("rst_state", 32'(state_o), 32'(READY));
    rst = 1'b0;
    #1;

    // Cold miss on 0x040 -> way0 of set 4
    refill("cold_040", 32'h040, 0, 32'hA000_0040);

    // 0x240 maps to set 4 as well -> fills the still-invalid way1
    i_pc_next = 32'h240;
    tick();
    refill("fill_240", 32'h240, 0, 32'hA000_0240);

    // Both lines resident
    i_pc_next = 32'h044;
    tick();
    expect_hit("hit_044", 32'hA000_0044);
    i_pc_next = 32'h244;
    tick();
    expect_hit("hit_244", 32'hA000_0244);

    // Set full: RR pointer 0 evicts way0; ARREADY held off 5 cycles with stray beats
    i_pc_next = 32'h440;
    tick();
    refill("evict_440", 32'h440, 5, 32'hA000_0440);

    i_pc_next = 32'h240;
    tick();
    expect_hit("kept_240", 32'hA000_0240);

    i_pc_next = 32'h040;
    tick();
    refill("again_040", 32'h040, 0, 32'hA000_0040);

    // Miss on 0x600 (set 0), abandoned by reset after two beats
    i_pc_next = 32'h600;
    tick();
`ifdef I_CACHE_PERF_EN
    check("perf_hits", hit_count, 32'(hits_seen));
    check("perf_misses", miss_count, 32'd4);
`endif
    check("part_miss_valid", 32'(out_valid_o), 32'd0);
    tick();
    check("part_araddr", mem_araddr_o, 32'h600);
    mem_arready_i = 1'b1;
    tick();
    mem_arready_i = 1'b0;
    check("part_data_state", 32'(state_o), 32'(REFILL_DATA));
    for (int b = 0; b < 2; b++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = word_at(32'h600 + 32'(4 * b));
      tick();
    end
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = JUNK;
    rst          = 1'b1;
    #1;
    check("midrst_state", 32'(state_o), 32'(READY));
    check("midrst_valid", 32'(out_valid_o), 32'd0);
    check("midrst_arvalid", 32'(mem_arvalid_o), 32'd0);
    check("midrst_rready", 32'(mem_rready_o), 32'd1);
`ifdef I_CACHE_PERF_EN
    check("midrst_hits", hit_count, 32'd0);
    check("midrst_misses", miss_count, 32'd0);
`endif
    tick();
    mem_rvalid_i = 1'b0;
    rst          = 1'b0;
    #1;

    // Refetch after reset misses; beat counter restarts at 0
    refill("after_rst_600", 32'h600, 1, 32'hA000_0600);

    // Line that was valid before reset must miss too
    i_pc_next = 32'h040;
    tick();
    refill("cleared_040", 32'h040, 0, 32'hA000_0040);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
